// File: rtl/fp_int_norm_if.sv
// Handshake and result bundle for fp_int_norm: start/operand in, normalized small-float out.
interface fp_int_norm_if #(
  parameter int ACC_W  = 32,
  parameter int MANT_W = 14,
  parameter int EXP_W  = 5
);
  logic              start;
  logic [ACC_W-1:0]  fixed_point_acc;
  logic [EXP_W-1:0]  exp_acc;
  logic              sign_out;
  logic [EXP_W-1:0]  exp_out;
  logic [MANT_W-1:0] mant_out;
  logic              busy;
  logic              done;
  logic              overflow;
  logic              underflow;
  logic              zero;

  modport master (
    output start, fixed_point_acc, exp_acc,
    input  sign_out, exp_out, mant_out, busy, done, overflow, underflow, zero
  );

  modport slave (
    input  start, fixed_point_acc, exp_acc,
    output sign_out, exp_out, mant_out, busy, done, overflow, underflow, zero
  );
endinterface

// File: rtl/fp_int_norm.sv
// Fixed-point accumulator -> sign/exp/mantissa normalizer; one bit of shift per cycle.
// Latency: done at E(2+N), N shifts (max E20). start is ignored while busy, accepted in IDLE.
// Optional FP_INT_NORM_ROUND_NEAREST_EN: round-to-nearest-even on the finishing edge (default truncates).
module fp_int_norm #(
  parameter int ACC_W  = 32,
  parameter int MANT_W = 14,
  parameter int EXP_W  = 5
) (
  input logic          clk,
  input logic          rst,
  fp_int_norm_if.slave io
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t state_q, state_d;

  logic [ACC_W-1:0]  mag_q, mag_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              sign_q, sign_d;
  logic              sign_out_q, sign_out_d;
  logic [EXP_W-1:0]  exp_out_q, exp_out_d;
  logic [MANT_W-1:0] mant_out_q, mant_out_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              zero_q, zero_d;
`ifdef FP_INT_NORM_ROUND_NEAREST_EN
  logic              guard_q, guard_d;
  logic              sticky_q, sticky_d;
  logic [MANT_W:0]   mant_inc;
`endif

  logic fin;
  logic busy;
  logic hi_nz;
  logic exp_max;
  logic lead;

  localparam logic [MANT_W-1:0] MANT_ONE = {1'b1, {(MANT_W-1){1'b0}}};

  assign hi_nz   = |mag_q[ACC_W-1:MANT_W];
  assign exp_max = &exp_q;
  assign lead    = mag_q[MANT_W-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (io.start) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (fin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == LOAD) || (state_q == SHIFT);
  end

  always_comb begin
    mag_d      = mag_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    sign_out_d = sign_out_q;
    exp_out_d  = exp_out_q;
    mant_out_d = mant_out_q;
    done_d     = done_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    zero_d     = zero_q;
    fin        = 1'b0;
`ifdef FP_INT_NORM_ROUND_NEAREST_EN
    guard_d    = guard_q;
    sticky_d   = sticky_q;
    mant_inc   = {1'b0, mag_q[MANT_W-1:0]} + (MANT_W+1)'(1);
`endif
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          mag_d  = io.fixed_point_acc;
          exp_d  = io.exp_acc;
          done_d = 1'b0;
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          zero_d = 1'b0;
`ifdef FP_INT_NORM_ROUND_NEAREST_EN
          guard_d  = 1'b0;
          sticky_d = 1'b0;
`endif
        end
      end
      LOAD: begin
        // mag_q still holds the raw two's-complement value here; 0x8000_0000 maps to 2^31
        sign_d = mag_q[ACC_W-1];
        mag_d  = mag_q[ACC_W-1] ? (~mag_q + ACC_W'(1)) : mag_q;
      end
      SHIFT: begin
        if (mag_q == '0) begin
          fin        = 1'b1;
          sign_out_d = 1'b0;
          exp_out_d  = '0;
          mant_out_d = '0;
          zero_d     = 1'b1;
          done_d     = 1'b1;
        end else if (hi_nz && exp_max) begin
          fin        = 1'b1;
          sign_out_d = sign_q;
          exp_out_d  = '1;
          mant_out_d = '1;
          ovf_d      = 1'b1;
          done_d     = 1'b1;
        end else if (hi_nz) begin
          mag_d = mag_q >> 1;
          exp_d = exp_q + EXP_W'(1);
`ifdef FP_INT_NORM_ROUND_NEAREST_EN
          guard_d  = mag_q[0];
          sticky_d = sticky_q | guard_q;
`endif
        end else if (!lead && (exp_q == '0)) begin
          fin        = 1'b1;
          sign_out_d = sign_q;
          exp_out_d  = '0;
          mant_out_d = mag_q[MANT_W-1:0];
          unf_d      = 1'b1;
          done_d     = 1'b1;
        end else if (!lead) begin
          mag_d = mag_q << 1;
          exp_d = exp_q - EXP_W'(1);
        end else begin
          fin        = 1'b1;
          sign_out_d = sign_q;
          exp_out_d  = exp_q;
          mant_out_d = mag_q[MANT_W-1:0];
          done_d     = 1'b1;
`ifdef FP_INT_NORM_ROUND_NEAREST_EN
          if (guard_q && (sticky_q || mag_q[0])) begin
            if (!mant_inc[MANT_W]) begin
              mant_out_d = mant_inc[MANT_W-1:0];
            end else if (exp_max) begin
              // carry out of the top exponent saturates like a right-shift overflow
              exp_out_d  = '1;
              mant_out_d = '1;
              ovf_d      = 1'b1;
            end else begin
              mant_out_d = MANT_ONE;
              exp_out_d  = exp_q + EXP_W'(1);
            end
          end
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag_q      <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      sign_out_q <= 1'b0;
      exp_out_q  <= '0;
      mant_out_q <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      zero_q     <= 1'b0;
`ifdef FP_INT_NORM_ROUND_NEAREST_EN
      guard_q    <= 1'b0;
      sticky_q   <= 1'b0;
`endif
    end else begin
      mag_q      <= mag_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      sign_out_q <= sign_out_d;
      exp_out_q  <= exp_out_d;
      mant_out_q <= mant_out_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      zero_q     <= zero_d;
`ifdef FP_INT_NORM_ROUND_NEAREST_EN
      guard_q    <= guard_d;
      sticky_q   <= sticky_d;
`endif
    end
  end

  assign io.sign_out  = sign_out_q;
  assign io.exp_out   = exp_out_q;
  assign io.mant_out  = mant_out_q;
  assign io.busy      = busy;
  assign io.done      = done_q;
  assign io.overflow  = ovf_q;
  assign io.underflow = unf_q;
  assign io.zero      = zero_q;

endmodule

// File: tb/tb_fp_int_norm.sv
// Directed-vector bench for fp_int_norm: latency, result fields, flags, busy-start and mid-op reset.
module tb_fp_int_norm;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   lat;

  fp_int_norm_if io ();

  fp_int_norm dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Starts one operation and returns the edge index (E_k) at which done is first seen.
  task automatic run_op(input logic [31:0] a, input logic [4:0] e, output int k_done);
    @(negedge clk);
    io.start           = 1'b1;
    io.fixed_point_acc = a;
    io.exp_acc         = e;
    @(posedge clk);
    #1;
    io.start           = 1'b0;
    io.fixed_point_acc = $urandom;
    io.exp_acc         = 5'($urandom_range(0, 31));
    chk("done_drop", {31'd0, io.done}, 32'd0);
    k_done = -1;
    for (int k = 1; k <= 40 && k_done < 0; k++) begin
      @(posedge clk);
      #1;
      if (io.done) k_done = k;
    end
  endtask

  task automatic check_res(input string tag, input int lat_got, input int lat_want,
                           input logic s, input logic [4:0] e, input logic [13:0] m,
                           input logic ov, input logic un, input logic z);
    chk({tag, "_lat"},   32'(lat_got), 32'(lat_want));
    chk({tag, "_sign"},  {31'd0, io.sign_out}, {31'd0, s});
    chk({tag, "_exp"},   {27'd0, io.exp_out}, {27'd0, e});
    chk({tag, "_mant"},  {18'd0, io.mant_out}, {18'd0, m});
    chk({tag, "_flags"}, {29'd0, io.overflow, io.underflow, io.zero}, {29'd0, ov, un, z});
    chk({tag, "_busy"},  {31'd0, io.busy}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_outs"},
        {7'd0, io.sign_out, io.exp_out, io.mant_out, io.busy, io.done,
         io.overflow, io.underflow, io.zero},
        32'd0);
  endtask

  initial begin
    total              = 0;
    bad                = 0;
    io.start           = 1'b0;
    io.fixed_point_acc = '0;
    io.exp_acc         = '0;
    rst                = 1'b1;
    #2 rst = 1'b0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    run_op(32'h0000_2000, 5'd10, lat);
    check_res("norm", lat, 2, 1'b0, 5'd10, 14'h2000, 1'b0, 1'b0, 1'b0);

    run_op(32'h0000_0001, 5'd20, lat);
    check_res("left13", lat, 15, 1'b0, 5'd7, 14'h2000, 1'b0, 1'b0, 1'b0);

    run_op(32'h0000_0000, 5'd9, lat);
    check_res("zero", lat, 2, 1'b0, 5'd0, 14'h0000, 1'b0, 1'b0, 1'b1);

    run_op(32'h8000_0000, 5'd3, lat);
    check_res("minneg", lat, 20, 1'b1, 5'd21, 14'h2000, 1'b0, 1'b0, 1'b0);

    run_op(32'h4000_0000, 5'd20, lat);
    check_res("ovf", lat, 13, 1'b0, 5'd31, 14'h3FFF, 1'b1, 1'b0, 1'b0);

    run_op(32'hFFFF_FFFD, 5'd0, lat);
    check_res("unf", lat, 2, 1'b1, 5'd0, 14'h0003, 1'b0, 1'b1, 1'b0);

`ifdef FP_INT_NORM_ROUND_NEAREST_EN
    run_op(32'h0000_7FFF, 5'd0, lat);
    check_res("rnd_carry", lat, 3, 1'b0, 5'd2, 14'h2000, 1'b0, 1'b0, 1'b0);
`else
    run_op(32'h0000_7FFF, 5'd0, lat);
    check_res("trunc", lat, 3, 1'b0, 5'd1, 14'h3FFF, 1'b0, 1'b0, 1'b0);
`endif

    run_op(32'h0000_6001, 5'd0, lat);
    check_res("tie_even", lat, 3, 1'b0, 5'd1, 14'h3000, 1'b0, 1'b0, 1'b0);

    // start held high across a whole operation: exactly one result at E15
    @(negedge clk);
    io.start           = 1'b1;
    io.fixed_point_acc = 32'h0000_0001;
    io.exp_acc         = 5'd20;
    @(posedge clk);
    #1;
    io.fixed_point_acc = 32'h0000_2000;
    io.exp_acc         = 5'd10;
    begin
      int early_done;
      int busy_lo;
      early_done = 0;
      busy_lo    = 0;
      for (int k = 1; k <= 14; k++) begin
        @(posedge clk);
        #1;
        if (io.done) early_done++;
        if (!io.busy) busy_lo++;
      end
      chk("hold_early_done", 32'(early_done), 32'd0);
      chk("hold_busy", 32'(busy_lo), 32'd0);
    end
    @(posedge clk);
    #1;
    io.start = 1'b0;
    chk("hold_done", {31'd0, io.done}, 32'd1);
    chk("hold_mant", {18'd0, io.mant_out}, 32'h2000);
    chk("hold_exp", {27'd0, io.exp_out}, 32'd7);
    @(posedge clk);
    #1;
    chk("idle_hold_done", {31'd0, io.done}, 32'd1);
    chk("idle_hold_mant", {18'd0, io.mant_out}, 32'h2000);

    // reset asserted mid-operation at E5
    @(negedge clk);
    io.start           = 1'b1;
    io.fixed_point_acc = 32'h8000_0000;
    io.exp_acc         = 5'd3;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst = 1'b1;

    run_op(32'h0000_2000, 5'd10, lat);
    check_res("after_rst", lat, 2, 1'b0, 5'd10, 14'h2000, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
